// File: rtl/comm_arbiter.sv
// comm_arbiter: round-robin arbiter sharing one CommMaster command link between
// two requesters (0 = host sequencer, 1 = telemetry poller).
//
// Each grant launches one cmd/data frame and waits for frame-sent, then for the
// response, under a cycle timeout. The response byte and an error flag are then
// returned to the granted requester.
//
// Optional build macro COMM_ARB_RETRY_EN: when it is defined, a timeout relaunches
// the same frame up to MAX_RETRY times before reporting err. The default build
// (macro undefined) reports err on the first timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no transaction; pick a winner when any req is high
// LAUNCH    | one-cycle snd_cmd pulse; flush stale response; clear timer
// WAIT_FRM  | waiting for CommMaster frm_snt; timer running
// WAIT_RESP | waiting for resp_rdy; timer still running
// DONE      | one-cycle done pulse to the granted requester; release grant

module comm_arbiter #(
    parameter int TIMEOUT_CYC = 500000,
    parameter int TMR_W       = 20,
    parameter int MAX_RETRY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [7:0]  cmd0,
    input  logic [7:0]  cmd1,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic        err,
    output logic [7:0]  resp_out,
    output logic        snd_cmd,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    input  logic        frm_snt,
    input  logic        resp_rdy,
    input  logic [7:0]  resp,
    output logic        clr_resp_rdy
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LAUNCH    = 3'd1;
    localparam logic [2:0] ST_WAIT_FRM  = 3'd2;
    localparam logic [2:0] ST_WAIT_RESP = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    logic [2:0]       state;
    logic [TMR_W-1:0] timer;
    logic             last_served;
    logic             win;
    logic             timeout;
    logic             resp_take;
    logic             waiting;
    logic             retry_ok;

    assign waiting   = (state == ST_WAIT_FRM) || (state == ST_WAIT_RESP);
    assign timeout   = (timer == TMR_LAST);
    assign resp_take = (state == ST_WAIT_RESP) && resp_rdy;

    // Winner selection: on a tie the requester not served last wins
    always_comb begin
        win = req[1];
        if (req == 2'b11) begin
            win = ~last_served;
        end
    end

`ifdef COMM_ARB_RETRY_EN
    localparam int RC_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic [RC_W-1:0] retry_cnt;

    assign retry_ok = (retry_cnt < RC_W'(MAX_RETRY));

    // Retry counter: counts relaunches of the current frame, cleared per transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt <= '0;
        end else if (state == ST_DONE) begin
            retry_cnt <= '0;
        end else if (waiting && !resp_take && timeout && retry_ok) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end
`else
    // Never true for a legal MAX_RETRY: without retries the first timeout is final
    assign retry_ok = (MAX_RETRY < 0);
`endif

    // Main sequencing FSM with grant, frame latch, timer and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            timer       <= '0;
            grant       <= 2'b00;
            err         <= 1'b0;
            resp_out    <= 8'h00;
            cmd         <= 8'h00;
            data        <= 16'h0000;
            last_served <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req != 2'b00) begin
                        grant <= win ? 2'b10 : 2'b01;
                        cmd   <= win ? cmd1 : cmd0;
                        data  <= win ? data1 : data0;
                        state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    timer <= '0;
                    state <= ST_WAIT_FRM;
                end
                ST_WAIT_FRM, ST_WAIT_RESP: begin
                    if (resp_take) begin
                        resp_out <= resp;
                        err      <= 1'b0;
                        state    <= ST_DONE;
                    end else if (timeout) begin
                        if (retry_ok) begin
                            state <= ST_LAUNCH;
                        end else begin
                            err   <= 1'b1;
                            state <= ST_DONE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                        if ((state == ST_WAIT_FRM) && frm_snt) begin
                            state <= ST_WAIT_RESP;
                        end
                    end
                end
                ST_DONE: begin
                    grant       <= 2'b00;
                    last_served <= grant[1];
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Single-cycle strobes decoded from state; a timed-out transaction has no response to clear
    assign snd_cmd      = (state == ST_LAUNCH);
    assign clr_resp_rdy = (state == ST_LAUNCH) || ((state == ST_DONE) && !err);
    assign done         = (state == ST_DONE) ? grant : 2'b00;

endmodule

// File: tb/tb_comm_arbiter.sv
// tb_comm_arbiter: scoreboard bench for comm_arbiter with a directed CommMaster stub.
// Expected completions are queued when stimulus is issued; the monitor checks each done.
// Build with or without COMM_ARB_RETRY_EN; the timeout scenarios follow the build.

module tb_comm_arbiter;

    localparam int TO_CYC = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [7:0]  cmd0, cmd1;
    logic [15:0] data0, data1;
    logic [1:0]  grant, done;
    logic        err;
    logic [7:0]  resp_out;
    logic        snd_cmd;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        frm_snt;
    logic        resp_rdy;
    logic [7:0]  resp;
    logic        clr_resp_rdy;

    typedef struct packed {
        logic [1:0] g;
        logic       e;
        logic [7:0] r;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   snd_cnt = 0;
    int   cyc;

    comm_arbiter #(
        .TIMEOUT_CYC(TO_CYC),
        .TMR_W(8),
        .MAX_RETRY(2)
    ) dut (
        .clk(clk), .rst(rst), .req(req),
        .cmd0(cmd0), .cmd1(cmd1), .data0(data0), .data1(data1),
        .grant(grant), .done(done), .err(err), .resp_out(resp_out),
        .snd_cmd(snd_cmd), .cmd(cmd), .data(data),
        .frm_snt(frm_snt), .resp_rdy(resp_rdy), .resp(resp),
        .clr_resp_rdy(clr_resp_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: counts launches and scores every done pulse against the queue
    always @(negedge clk) begin
        if (snd_cmd) snd_cnt++;
        if (done != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {30'd0, done}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("done_grant", {30'd0, done}, {30'd0, mon_e.g});
                check("done_err", {31'd0, err}, {31'd0, mon_e.e});
                check("done_resp", {24'd0, resp_out}, {24'd0, mon_e.r});
                check("done_clr", {31'd0, clr_resp_rdy}, {31'd0, !mon_e.e});
            end
        end
    end

    task automatic wait_snd(input int limit);
        int i;
        i = 0;
        @(negedge clk);
        while (!snd_cmd && i < limit) begin
            @(negedge clk);
            i++;
        end
        check("snd_cmd_seen", {31'd0, snd_cmd}, 32'd1);
    endtask

    task automatic wait_done(input int limit);
        int i;
        i = 0;
        @(negedge clk);
        while (done == 2'b00 && i < limit) begin
            @(negedge clk);
            i++;
        end
        check("done_seen", {31'd0, done != 2'b00}, 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_grant"}, {30'd0, grant}, 32'd0);
        check({tag, "_done"}, {30'd0, done}, 32'd0);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_resp_out"}, {24'd0, resp_out}, 32'd0);
        check({tag, "_snd_cmd"}, {31'd0, snd_cmd}, 32'd0);
        check({tag, "_cmd"}, {24'd0, cmd}, 32'd0);
        check({tag, "_data"}, {16'd0, data}, 32'd0);
        check({tag, "_clr"}, {31'd0, clr_resp_rdy}, 32'd0);
    endtask

    // One transaction from launch to grant release; returns in the IDLE cycle after DONE
    task automatic serve(input logic [1:0] g, input logic [7:0] c, input logic [15:0] d,
                         input logic [7:0] r);
        wait_snd(20);
        check("launch_grant", {30'd0, grant}, {30'd0, g});
        check("launch_cmd", {24'd0, cmd}, {24'd0, c});
        check("launch_data", {16'd0, data}, {16'd0, d});
        check("launch_clr", {31'd0, clr_resp_rdy}, 32'd1);
        @(posedge clk); #1 frm_snt = 1'b1;
        @(posedge clk); #1 frm_snt = 1'b0; resp_rdy = 1'b1; resp = r;
        @(posedge clk);
        @(negedge clk);
        check("done_latency", {30'd0, done}, {30'd0, g});
        resp_rdy = 1'b0;
        @(negedge clk);
        check("grant_release", {30'd0, grant}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; cmd0 = 8'h00; cmd1 = 8'h00; data0 = 16'h0; data1 = 16'h0;
        frm_snt = 1'b0; resp_rdy = 1'b0; resp = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Single request with loopback answer A5
        cmd0 = 8'h20; data0 = 16'h0060;
        exp_q.push_back('{2'b01, 1'b0, 8'hA5});
        snd_cnt = 0;
        req = 2'b01;
        serve(2'b01, 8'h20, 16'h0060, 8'hA5);
        req = 2'b00;
        check("single_snd_cnt", snd_cnt, 32'd1);

        // Tie from reset: alternating grants
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmd0 = 8'h43; cmd1 = 8'h93; data0 = 16'h1111; data1 = 16'h2222;
        exp_q.push_back('{2'b01, 1'b0, 8'h11});
        exp_q.push_back('{2'b10, 1'b0, 8'h22});
        exp_q.push_back('{2'b01, 1'b0, 8'h33});
        exp_q.push_back('{2'b10, 1'b0, 8'h44});
        req = 2'b11;
        serve(2'b01, 8'h43, 16'h1111, 8'h11);
        serve(2'b10, 8'h93, 16'h2222, 8'h22);
        serve(2'b01, 8'h43, 16'h1111, 8'h33);
        serve(2'b10, 8'h93, 16'h2222, 8'h44);
        req = 2'b00;

        // Silent remote: timeout, resp_out keeps 44
        cmd0 = 8'h5C; data0 = 16'hBEEF;
        exp_q.push_back('{2'b01, 1'b1, 8'h44});
        snd_cnt = 0;
        req = 2'b01;
`ifndef COMM_ARB_RETRY_EN
        wait_snd(20);
        @(posedge clk);
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done != 2'b00) break;
            @(posedge clk);
            cyc++;
        end
        check("timeout_cycles", cyc, TO_CYC);
        check("timeout_snd_cnt", snd_cnt, 32'd1);
`else
        wait_done(400);
        check("retry_silent_snd_cnt", snd_cnt, 32'd3);
`endif
        req = 2'b00;
        repeat (2) @(negedge clk);

        // Stale resp_rdy before launch: flushed, ignored until frm_snt
        resp_rdy = 1'b1; resp = 8'h77;
        cmd1 = 8'hC1; data1 = 16'h0A0B;
        req = 2'b10;
        wait_snd(20);
        check("stale_grant", {30'd0, grant}, 32'd2);
        check("stale_launch_clr", {31'd0, clr_resp_rdy}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stale_no_done", {30'd0, done}, 32'd0);
        end
        exp_q.push_back('{2'b10, 1'b0, 8'h77});
        frm_snt = 1'b1;
        @(posedge clk); #1 frm_snt = 1'b0;
        wait_done(10);
        resp_rdy = 1'b0;
        req = 2'b00;
        repeat (2) @(negedge clk);

        // Reset during WAIT_RESP, then a normal request from requester 1
        cmd0 = 8'h31; data0 = 16'h3131;
        req = 2'b01;
        wait_snd(20);
        @(posedge clk); #1 frm_snt = 1'b1;
        @(posedge clk); #1 frm_snt = 1'b0;
        @(negedge clk);
        rst = 1'b1; req = 2'b00;
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        cmd1 = 8'h5A; data1 = 16'h1234;
        exp_q.push_back('{2'b10, 1'b0, 8'hC3});
        req = 2'b10;
        serve(2'b10, 8'h5A, 16'h1234, 8'hC3);
        req = 2'b00;

`ifdef COMM_ARB_RETRY_EN
        // Remote answers FF on the second attempt
        cmd0 = 8'h66; data0 = 16'h0102;
        exp_q.push_back('{2'b01, 1'b0, 8'hFF});
        snd_cnt = 0;
        req = 2'b01;
        wait_snd(20);
        wait_snd(100);
        @(posedge clk); #1 frm_snt = 1'b1;
        @(posedge clk); #1 frm_snt = 1'b0; resp_rdy = 1'b1; resp = 8'hFF;
        wait_done(5);
        resp_rdy = 1'b0;
        req = 2'b00;
        check("retry_answer_snd_cnt", snd_cnt, 32'd2);
`endif

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
